// File: rtl/scratch_pad_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : scratch_pad_req_queue
// Purpose  : Per-port request queue placed directly upstream of one
//            scratch_pad port. It buffers client read/write requests in a
//            circular FIFO. It issues the head request only while the port
//            is not full. Outstanding reads are limited to MAX_RD credits,
//            which are returned by sp_valid pulses.
// Ports    : clk, rst (async, active high)
//            req_rd/req_wr/req_addr/req_d -> client request in
//            req_full                     -> queue cannot accept a request
//            sp_rd_en/sp_wr_en/sp_addr/sp_d -> issue to scratch_pad port
//            sp_full, sp_valid            -> port backpressure / read return
//            idle  -> FIFO empty and no reads outstanding
//            err   -> sticky protocol-error flag
// Options  : SCRATCH_PAD_REQ_STATS_EN adds rd_issued, wr_issued and
//            stall_cycles counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
module scratch_pad_req_queue #(
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int MAX_RD     = 4
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  req_rd,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_d,
  output logic                  req_full,
  output logic                  sp_rd_en,
  output logic                  sp_wr_en,
  output logic [ADDR_WIDTH-1:0] sp_addr,
  output logic [WIDTH-1:0]      sp_d,
  input  logic                  sp_full,
  input  logic                  sp_valid,
  output logic                  idle,
  output logic                  err
`ifdef SCRATCH_PAD_REQ_STATS_EN
  ,
  output logic [31:0]           rd_issued,
  output logic [31:0]           wr_issued,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(MAX_RD) + 1;
  localparam logic [c_PTR_W:0]   c_DEPTH  = (c_PTR_W + 1)'(DEPTH);
  localparam logic [c_PTR_W:0]   c_PTR_1  = (c_PTR_W + 1)'(1);
  localparam logic [c_CNT_W-1:0] c_MAX_RD = c_CNT_W'(MAX_RD);
  localparam logic [c_CNT_W-1:0] c_CNT_1  = c_CNT_W'(1);

  // FIFO storage, split by field; not reset since only occupied slots are read
  logic                  r_mem_wr   [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [WIDTH-1:0]      r_mem_d    [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty
  logic [c_PTR_W:0]      r_wptr;
  logic [c_PTR_W:0]      r_rptr;
  logic [c_PTR_W:0]      w_wptr_nxt;
  logic [c_PTR_W:0]      w_rptr_nxt;
  logic                  r_full;
  logic [c_CNT_W-1:0]    r_rd_out;
  logic                  r_err;
  // Last popped entry, shown on sp_addr/sp_d while the FIFO is empty
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [WIDTH-1:0]      r_last_d;

  logic w_empty;
  logic w_head_wr;
  logic w_issue;
  logic w_pop;
  logic w_push;
  logic w_rd_issue;
  logic w_ret;
  logic w_err_evt;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_head_wr = r_mem_wr[r_rptr[c_PTR_W-1:0]];

  // Credit check uses the registered count only; a same-cycle sp_valid
  // does not free a credit until the next cycle.
  assign w_issue    = !w_empty && !sp_full && (w_head_wr || (r_rd_out < c_MAX_RD));
  assign sp_wr_en   = w_issue && w_head_wr;
  assign sp_rd_en   = w_issue && !w_head_wr;
  assign w_rd_issue = sp_rd_en;
  assign w_pop      = w_issue;

  assign sp_addr = w_empty ? r_last_addr : r_mem_addr[r_rptr[c_PTR_W-1:0]];
  assign sp_d    = w_empty ? r_last_d    : r_mem_d[r_rptr[c_PTR_W-1:0]];

  // Push only with exactly one request type and a free slot as seen by
  // the registered full flag.
  assign w_push = (req_rd ^ req_wr) && !r_full;
  assign w_ret  = sp_valid && (r_rd_out != '0);

  assign w_err_evt = (req_rd && req_wr)
                   || ((req_rd || req_wr) && r_full)
                   || (sp_valid && (r_rd_out == '0));

  assign w_wptr_nxt = w_push ? (r_wptr + c_PTR_1) : r_wptr;
  assign w_rptr_nxt = w_pop  ? (r_rptr + c_PTR_1) : r_rptr;

  assign req_full = r_full;
  assign idle     = w_empty && (r_rd_out == '0);
  assign err      = r_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_wr[r_wptr[c_PTR_W-1:0]]   <= req_wr;
      r_mem_addr[r_wptr[c_PTR_W-1:0]] <= req_addr;
      r_mem_d[r_wptr[c_PTR_W-1:0]]    <= req_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_full      <= 1'b0;
      r_rd_out    <= '0;
      r_err       <= 1'b0;
      r_last_addr <= '0;
      r_last_d    <= '0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      r_full <= ((w_wptr_nxt - w_rptr_nxt) == c_DEPTH);
      r_err  <= r_err || w_err_evt;
      if (w_pop) begin
        r_last_addr <= sp_addr;
        r_last_d    <= sp_d;
      end
      case ({w_rd_issue, w_ret})
        2'b10:   r_rd_out <= r_rd_out + c_CNT_1;
        2'b01:   r_rd_out <= r_rd_out - c_CNT_1;
        default: r_rd_out <= r_rd_out;
      endcase
    end
  end

`ifdef SCRATCH_PAD_REQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_issued    <= '0;
      wr_issued    <= '0;
      stall_cycles <= '0;
    end else begin
      if (sp_rd_en) rd_issued <= rd_issued + 32'd1;
      if (sp_wr_en) wr_issued <= wr_issued + 32'd1;
      // Head waiting on port backpressure or on a read credit
      if (!w_empty && !w_issue) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_scratch_pad_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_scratch_pad_req_queue
// Purpose  : Self-checking bench for scratch_pad_req_queue. It uses a queue
//            based reference model, a directed vector table, hand-written
//            corner sequences and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scratch_pad_req_queue;

  localparam int W      = 64;
  localparam int AW     = 12;
  localparam int DEPTH  = 8;
  localparam int MAX_RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_rd = 1'b0, req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_d = '0;
  logic          sp_full = 1'b0, sp_valid = 1'b0;
  logic          req_full, sp_rd_en, sp_wr_en, idle, err;
  logic [AW-1:0] sp_addr;
  logic [W-1:0]  sp_d;
`ifdef SCRATCH_PAD_REQ_STATS_EN
  logic [31:0]   rd_issued, wr_issued, stall_cycles;
`endif

  always #5 clk = ~clk;

  scratch_pad_req_queue #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .MAX_RD(MAX_RD)) dut (
    .rst(rst), .clk(clk), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_d(req_d), .req_full(req_full), .sp_rd_en(sp_rd_en), .sp_wr_en(sp_wr_en),
    .sp_addr(sp_addr), .sp_d(sp_d), .sp_full(sp_full), .sp_valid(sp_valid),
    .idle(idle), .err(err)
`ifdef SCRATCH_PAD_REQ_STATS_EN
    , .rd_issued(rd_issued), .wr_issued(wr_issued), .stall_cycles(stall_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the queued requests in order, read credits in use,
  // sticky error and the last popped entry.
  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } ent_t;
  ent_t          q[$];
  int            m_rd_out;
  logic          m_err;
  logic [AW-1:0] m_last_a;
  logic [W-1:0]  m_last_d;
  int            m_nrd, m_nwr, m_nstall;

  // Values sampled mid-cycle by the last step
  logic          s_wr_en, s_rd_en, s_idle, s_err;
  logic [AW-1:0] s_addr;
  logic [W-1:0]  s_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_rd_out = 0;
    m_err    = 1'b0;
    m_last_a = '0;
    m_last_d = '0;
    m_nrd = 0; m_nwr = 0; m_nstall = 0;
  endtask

  // Entered 1 time unit after a rising edge; returns at the same point of
  // the next cycle.
  task automatic step(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [W-1:0] d, input logic spf, input logic spv);
    logic          e_full, e_iss, e_wr;
    logic [AW-1:0] e_a;
    logic [W-1:0]  e_d;
    int            pre;
    ent_t          h;
    ent_t          n;
    req_rd = rd; req_wr = wr; req_addr = a; req_d = d; sp_full = spf; sp_valid = spv;
    #4;
    e_full = (q.size() == DEPTH);
    e_wr   = (q.size() > 0) && q[0].w;
    e_iss  = (q.size() > 0) && !spf && (q[0].w || (m_rd_out < MAX_RD));
    e_a    = (q.size() > 0) ? q[0].a : m_last_a;
    e_d    = (q.size() > 0) ? q[0].d : m_last_d;
    s_wr_en = sp_wr_en; s_rd_en = sp_rd_en; s_idle = idle; s_err = err;
    s_addr  = sp_addr;  s_d = sp_d;
    chk("req_full", 64'(req_full), 64'(e_full));
    chk("sp_wr_en", 64'(sp_wr_en), 64'(e_iss && e_wr));
    chk("sp_rd_en", 64'(sp_rd_en), 64'(e_iss && !e_wr));
    chk("sp_addr",  64'(sp_addr),  64'(e_a));
    chk("sp_d",     sp_d,          e_d);
    chk("idle",     64'(idle),     64'((q.size() == 0) && (m_rd_out == 0)));
    chk("err",      64'(err),      64'(m_err));
`ifdef SCRATCH_PAD_REQ_STATS_EN
    chk("rd_issued",    64'(rd_issued),    64'(m_nrd));
    chk("wr_issued",    64'(wr_issued),    64'(m_nwr));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_nstall));
`endif
    @(posedge clk);
    pre = m_rd_out;
    if (q.size() > 0 && !e_iss) m_nstall++;
    if (e_iss) begin
      h = q.pop_front();
      m_last_a = h.a;
      m_last_d = h.d;
      if (h.w) m_nwr++;
      else begin
        m_nrd++;
        m_rd_out++;
      end
    end
    if (spv) begin
      if (pre == 0) m_err = 1'b1;
      else m_rd_out--;
    end
    if (rd && wr) m_err = 1'b1;
    else if ((rd || wr) && e_full) m_err = 1'b1;
    else if (rd || wr) begin
      n.w = wr; n.a = a; n.d = d;
      q.push_back(n);
    end
    #1;
  endtask

  // Asynchronous reset, checked before any clock edge arrives
  task automatic do_reset();
    req_rd = 1'b0; req_wr = 1'b0; sp_full = 1'b0; sp_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst idle",     64'(idle),     64'd1);
    chk("rst sp_rd_en", 64'(sp_rd_en), 64'd0);
    chk("rst sp_wr_en", 64'(sp_wr_en), 64'd0);
    chk("rst err",      64'(err),      64'd0);
    chk("rst req_full", 64'(req_full), 64'd0);
    chk("rst sp_addr",  64'(sp_addr),  64'd0);
    chk("rst sp_d",     sp_d,          64'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic          rd, wr;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic          spf, spv;
    logic          x_wr, x_rd;
    logic [AW-1:0] x_a;
    logic [W-1:0]  x_d;
    logic          x_idle, x_err;
  } vec_t;

  vec_t tbl[8];
  int   n;
  int   k;

  initial begin
    // Single write then read of address 5, credit return, then dual request
    //          rd   wr   addr   data    spf  spv | wr   rd   addr   data   idle err
    tbl[0] = '{1'b0,1'b1,12'd5,64'd42,1'b0,1'b0, 1'b0,1'b0,12'd0,64'd0, 1'b1,1'b0};
    tbl[1] = '{1'b1,1'b0,12'd5,64'd0, 1'b0,1'b0, 1'b1,1'b0,12'd5,64'd42,1'b0,1'b0};
    tbl[2] = '{1'b0,1'b0,12'd0,64'd0, 1'b0,1'b0, 1'b0,1'b1,12'd5,64'd0, 1'b0,1'b0};
    tbl[3] = '{1'b0,1'b0,12'd0,64'd0, 1'b0,1'b0, 1'b0,1'b0,12'd5,64'd0, 1'b0,1'b0};
    tbl[4] = '{1'b0,1'b0,12'd0,64'd0, 1'b0,1'b1, 1'b0,1'b0,12'd5,64'd0, 1'b0,1'b0};
    tbl[5] = '{1'b0,1'b0,12'd0,64'd0, 1'b0,1'b0, 1'b0,1'b0,12'd5,64'd0, 1'b1,1'b0};
    tbl[6] = '{1'b1,1'b1,12'd7,64'd9, 1'b0,1'b0, 1'b0,1'b0,12'd5,64'd0, 1'b1,1'b0};
    tbl[7] = '{1'b0,1'b0,12'd0,64'd0, 1'b0,1'b0, 1'b0,1'b0,12'd5,64'd0, 1'b1,1'b1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].spf, tbl[i].spv);
      chk($sformatf("vec%0d wr_en", i), 64'(s_wr_en), 64'(tbl[i].x_wr));
      chk($sformatf("vec%0d rd_en", i), 64'(s_rd_en), 64'(tbl[i].x_rd));
      chk($sformatf("vec%0d addr", i),  64'(s_addr),  64'(tbl[i].x_a));
      chk($sformatf("vec%0d d", i),     s_d,          tbl[i].x_d);
      chk($sformatf("vec%0d idle", i),  64'(s_idle),  64'(tbl[i].x_idle));
      chk($sformatf("vec%0d err", i),   64'(s_err),   64'(tbl[i].x_err));
    end

    // Backpressure: fill under sp_full, overflow attempt, then drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, AW'(16 + i), W'(3 * i + 1), 1'b1, 1'b0);
    chk("bp req_full", 64'(req_full), 64'd1);
    step(1'b0, 1'b1, 12'd99, 64'd99, 1'b1, 1'b0);
    chk("bp overflow err", 64'(err), 64'd1);
    n = 0; k = 16;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      if (s_wr_en) begin
        chk("bp order", 64'(s_addr), 64'(k));
        k++;
        n++;
      end
    end
    chk("bp issue count", 64'(n), 64'd8);

    // Credit limit: six reads, no returns, then one return
    do_reset();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, AW'(32 + i), '0, 1'b0, 1'b0);
      n += int'(s_rd_en);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      n += int'(s_rd_en);
    end
    chk("credit issue count", 64'(n), 64'd4);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    n += int'(s_rd_en);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      n += int'(s_rd_en);
    end
    chk("credit after return", 64'(n), 64'd5);

    // Read issue and sp_valid together at two outstanding, then underflow
    do_reset();
    step(1'b1, 1'b0, 12'd40, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12'd41, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12'd42, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("simul issue", 64'(s_rd_en), 64'd1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("simul idle after 1 return", 64'(idle), 64'd0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("simul idle after 2 returns", 64'(idle), 64'd1);
    chk("simul no err yet", 64'(err), 64'd0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("underflow err", 64'(err), 64'd1);
    chk("underflow idle", 64'(idle), 64'd1);

    // Wrap: 24 interleaved push/pop pairs
    do_reset();
    k = 0;
    for (int i = 0; i < 25; i++) begin
      if (i < 24) step(1'b0, 1'b1, AW'(i), W'(i + 100), 1'b0, 1'b0);
      else        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      if (s_wr_en) begin
        chk("wrap order", 64'(s_addr), 64'(k));
        k++;
      end
    end
    chk("wrap count", 64'(k), 64'd24);

    // Reset with three entries queued, then a stale sp_valid
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, AW'(50 + i), W'(i), 1'b1, 1'b0);
    do_reset();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("post-reset valid err", 64'(err), 64'd1);

    // Randomized traffic with one mid-run reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int   r;
      logic rd, wr, spv;
      if (i == 1500) do_reset();
      r   = int'($urandom_range(0, 19));
      rd  = (r < 6) || (r == 19);
      wr  = (r >= 6 && r < 12) || (r == 19);
      spv = (m_rd_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 299) == 0);
      step(rd, wr, AW'($urandom), {$urandom, $urandom}, $urandom_range(0, 3) == 0, spv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scratch_pad_req_queue.md
Name: scratch_pad_req_queue

Overview:
Per-port request queue sitting directly upstream of one scratch_pad port.
- Buffers client read/write requests in a small FIFO and issues them to the scratch_pad port only when that port is not full.
- Limits outstanding reads to a credit count, returned by the port's valid pulses.
- One instance per port (8 in the current scratch_pad configuration).

Parameters:
WIDTH, 64, data width; matches scratch_pad port data width.
ADDR_WIDTH, 12, address width; matches scratch_pad per-port address width.
DEPTH, 8, FIFO entries; power of two, at least 2.
MAX_RD, 4, maximum reads issued but not yet answered by sp_valid; at least 1.

Ports:
rst  input  1  asynchronous reset, active high
clk  input  1  clock, all state on rising edge
req_rd  input  1  client read request
req_wr  input  1  client write request
req_addr  input  ADDR_WIDTH  client address
req_d  input  WIDTH  client write data, ignored for reads
req_full  output  1  queue cannot accept a request this cycle
sp_rd_en  output  1  read issue to scratch_pad port
sp_wr_en  output  1  write issue to scratch_pad port
sp_addr  output  ADDR_WIDTH  issued address
sp_d  output  WIDTH  issued write data
sp_full  input  1  scratch_pad port full; no issue while high
sp_valid  input  1  scratch_pad read data returned for this port
idle  output  1  FIFO empty and zero reads outstanding
err  output  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied; outstanding-read count set to 0.
  - err=0, req_full=0, idle=1, sp_rd_en=0, sp_wr_en=0.
  - sp_addr and sp_d driven to 0.
- FIFO entry holds {is_wr, addr, data}. Circular buffer with read/write pointers of log2(DEPTH) bits plus one wrap bit.
- Push: accepted on a rising edge when exactly one of req_rd/req_wr is high and req_full=0.
- req_full:
  - Registered, high when occupancy == DEPTH.
  - Derived from registered occupancy only, so a pop in the same cycle does not open a slot for a push in that cycle.
- No fall-through. A request pushed at edge N is visible at the FIFO head after edge N and is issued at the earliest on edge N+1.
- Issue condition: head present AND sp_full=0 AND (head is write OR rd_out < MAX_RD).
  - The rd_out check uses the registered count; a same-cycle sp_valid does not grant an extra credit.
- sp_rd_en / sp_wr_en:
  - Combinational from head state, the issue condition and sp_full.
  - sp_addr/sp_d always show the head entry; they hold their last value when the FIFO is empty.
- Pop occurs on the edge where sp_rd_en or sp_wr_en is high. The scratch_pad samples the request on that same edge.
- Strict FIFO order: a read blocked by credits also blocks any write behind it.
- rd_out counter (log2(MAX_RD)+1 bits):
  - +1 on read issue, -1 on sp_valid; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_RD.
- idle = (occupancy == 0) && (rd_out == 0), combinational from registers.
- err is set, and held until reset, on any of:
  - req_rd and req_wr both high: request discarded, not pushed.
  - A request while req_full=1: request discarded.
  - sp_valid while rd_out == 0: counter stays 0, no underflow.
- Wrap-around: pointers wrap modulo DEPTH. Full/empty are distinguished by the wrap bit, so 3*DEPTH consecutive push/pop pairs must cause no corruption.
- Simultaneous push and pop at occupancy 1..DEPTH-1: occupancy unchanged, order preserved.
- Reset mid-operation discards queued and outstanding requests. Any sp_valid arriving after reset release is an underflow and sets err.

Optional Feature:
Macro SCRATCH_PAD_REQ_STATS_EN.
- Defined: adds output ports rd_issued[31:0] and wr_issued[31:0], plus a stall_cycles[31:0] counter.
  - rd_issued / wr_issued count issues; reset to 0; wrap at 2^32.
  - stall_cycles counts cycles where the head is present but not issued because of sp_full or missing credit.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Single write then read: push write addr=5 d=42, then read addr=5, sp_full=0 → sp_wr_en high the cycle after the push with sp_addr=5, sp_d=42. sp_rd_en follows one cycle later. rd_out=1 until sp_valid, then idle=1.
- Backpressure: hold sp_full=1, push 8 writes → req_full=1 after the 8th push, a 9th request sets err and is dropped. Release sp_full → 8 issues on consecutive cycles in push order.
- Credit limit: push 6 reads, sp_valid withheld → exactly 4 sp_rd_en pulses, then stall. One sp_valid → one more issue. rd_out never exceeds 4.
- Simultaneous read issue and sp_valid at rd_out=2 → rd_out stays 2. sp_valid at rd_out=0 → err=1, rd_out stays 0.
- Wrap and reset: 24 interleaved push/pop pairs with addresses 0..23 → issued addresses 0..23 in order. Assert rst with 3 entries queued → idle=1, sp_*_en=0 immediately, err=0.
- Both req_rd and req_wr high → no push, err=1. With SCRATCH_PAD_REQ_STATS_EN defined, rd_issued/wr_issued match the issued counts from the scenarios above.
